lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator for the word-wide data memory port (mem_read/mem_write/addr/write_data/read_data).
//  Takes one core request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW. Builds sub-word loads by extract plus extend,
//  and sub-word stores by read-modify-write, since the memory supports only whole-word writes.
//  Sits between the core execute/MEM stage and data memory. Flags misaligned, illegal and out-of-range accesses.
// PARAMETERS
//  MEM_BYTES     256  size of the backing memory in bytes; req_addr >= MEM_BYTES is an access fault
//  CHECK_BOUNDS  1    1 = enforce the MEM_BYTES fault; 0 = pass every address through to memory
// PORTS
//  clk         in   1   single clock; every register updates on posedge
//  rst         in   1   asynchronous reset, active-high
//  req_valid   in   1   core request present
//  req_ready   out  1   1 only in IDLE; a request is accepted when req_valid & req_ready at posedge
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  resp_valid  out  1   one-cycle completion pulse; no backpressure
//  resp_rdata  out  32  load result, extended; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: misaligned, illegal funct3, or out of bounds
//  mem_read    out  1   read enable to data memory
//  mem_write   out  1   write enable; memory commits on the posedge where this is 1
//  mem_addr    out  32  {addr[31:2],2'b00} while mem_read or mem_write is 1, else 0
//  mem_wdata   out  32  full word to store; 0 when mem_write=0
//  mem_rdata   in   32  combinational read data, valid in the same cycle as mem_read
// BEHAVIOUR
//  Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; mem_read=0, mem_write=0,
//   mem_addr=0, mem_wdata=0; req_ready=1. Reset mid-operation aborts with no resp and no mem_write.
//  FSM states: IDLE, RD, WR, RESP. Memory outputs decode from state only, never directly from req_*.
//  IDLE: on accept, latch we/funct3/addr/wdata and decode the error.
//   error -> RESP. LW/LB/LH/LBU/LHU -> RD. SW -> WR. SB/SH -> RD (then RMW).
//  Error rules:
//   - illegal funct3: load 011/110/111; store anything other than 000/001/010
//   - H misaligned: addr[0]!=0 for H/HU
//   - W misaligned: addr[1:0]!=0 for W
//   - bounds: CHECK_BOUNDS && addr>=MEM_BYTES
//  RD: mem_read=1. At posedge, capture mem_rdata into word_q.
//   load -> RESP; SB/SH -> WR.
//  WR: mem_write=1 for exactly one cycle, then RESP.
//   SW: mem_wdata=wdata.
//   SB: word_q with byte lane addr[1:0] replaced by wdata[7:0].
//   SH: word_q with half lane addr[1] replaced by wdata[15:0].
//  RESP: resp_valid=1 for one cycle, registered outputs, then IDLE; req_ready=0 in this cycle.
//  Load extract: byte = word_q>>(8*addr[1:0]); half = word_q>>(16*addr[1]).
//   B/H sign-extend from bit 7/15; BU/HU zero-extend.
//  resp_rdata and resp_err hold 0 outside RESP.
//  Latency, accept edge to resp_valid cycle: error 1, load 2, SW 2, SB/SH 3.
//   Throughput: one request per latency+1 cycles.
//  mem_read and mem_write are never both 1. No memory access on an errored request.
//  req_valid while busy is ignored and not queued; the core must hold it until req_ready.
//  Upper address bits pass through unchanged; memory aliasing is the memory's concern.
// TESTING
//  1. SW addr 0x10 data 0xDEADBEEF -> single WR cycle, mem_addr=0x10; resp 2 cycles after accept, err=0.
//     Then LW 0x10 -> resp_rdata=0xDEADBEEF.
//  2. SB 0x11 data 0x000000AA over 0xDEADBEEF -> RD then WR with mem_wdata=0xDEADAAEF.
//     Then LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
//  3. SH 0x12 data 0x00008234 -> word 0x8234AAEF.
//     Then LH 0x12 -> 0xFFFF8234; LHU 0x12 -> 0x00008234; LH 0x11 -> err.
//  4. Bad requests each give err=1 with no mem_read/mem_write and resp 1 cycle after accept:
//     LW 0x13 (misaligned); SH 0x01 (misaligned); store funct3=100 (illegal);
//     LW 0x100 with MEM_BYTES=256 (bounds).
//  5. req_valid held high during a SB -> second request accepted only on the cycle after resp_valid.
//     Back-to-back LW issue every 3 cycles.
//  6. Assert rst during the RD of SB 0x10 -> outputs 0 immediately, no mem_write, no resp.
//     After release req_ready=1; LW 0x10 returns the unchanged prior word.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core request/response and word-wide data memory port bundle
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-request load/store unit with sub-word extract and read-modify-write stores
module lsu_mem_master #(
    parameter int MEM_BYTES    = 256,
    parameter bit CHECK_BOUNDS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ill, mis, oob;
        ill = we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5);
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        oob = CHECK_BOUNDS && a >= 32'(MEM_BYTES);
        return ill || mis || oob;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic half, input logic [1:0] off, input logic [15:0] d);
        logic [31:0] m, v;
        m = half ? 32'h0000_FFFF << {off[1], 4'b0000} : 32'h0000_00FF << {off, 3'b000};
        v = half ? {16'h0, d} << {off[1], 4'b0000} : {24'h0, d[7:0]} << {off, 3'b000};
        return (w & ~m) | v;
    endfunction

    assign bus.req_ready = state == IDLE;

    // Request sequencing; all response and memory outputs are registered and cleared by default each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            f3_q           <= 3'b000;
            addr_q         <= 32'h0;
            wdata_q        <= 16'h0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= 32'h0;
            bus.mem_wdata  <= 32'h0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= 32'h0;
            bus.mem_wdata  <= 32'h0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    f3_q    <= bus.req_funct3;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata[15:0];
                    if (bad_req(bus.req_we, bus.req_funct3, bus.req_addr)) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                        state         <= WR;
                        bus.mem_write <= 1'b1;
                        bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        bus.mem_wdata <= bus.req_wdata;
                    end else begin
                        state        <= RD;
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                    end
                end
                RD: if (we_q) begin
                    state         <= WR;
                    bus.mem_write <= 1'b1;
                    bus.mem_addr  <= {addr_q[31:2], 2'b00};
                    bus.mem_wdata <= merge(bus.mem_rdata, f3_q[0], addr_q[1:0], wdata_q);
                end else begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_ext(bus.mem_rdata, f3_q, addr_q[1:0]);
                end
                WR: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed table, corner sequences and random traffic against a byte-level model
module tb_lsu_mem_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] dmem [64];
    logic [7:0]  refm [256];

    lsu_mem_master_if bus();
    lsu_mem_master #(.MEM_BYTES(256), .CHECK_BOUNDS(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A3C_C3A5;
    endfunction

    // Word-wide memory: combinational read, write commits on the clock edge
    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
        else if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: legality, alignment and bounds from the rules, data assembled byte by byte
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic er, output int lat, output int nr, output int nw,
                                  output logic [31:0] ww);
        int sz;
        logic ill;
        logic [31:0] v;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        er = ill || (a % sz != 0) || (a >= 256);
        rd = 0; ww = 0; nr = 0; nw = 0; lat = 1;
        if (er) return;
        if (!we) begin
            v = 0;
            for (int i = 0; i < sz; i++) v |= 32'(refm[a + i]) << (8 * i);
            if (!f3[2] && sz < 4) v = (sz == 1) ? {{24{v[7]}}, v[7:0]} : {{16{v[15]}}, v[15:0]};
            rd = v; nr = 1; lat = 2;
        end else begin
            for (int i = 0; i < sz; i++) refm[a + i] = d[8 * i +: 8];
            for (int i = 0; i < 4; i++) ww[8 * i +: 8] = refm[(a & ~32'd3) + i];
            nw = 1; nr = (sz < 4) ? 1 : 0; lat = (sz < 4) ? 3 : 2;
        end
    endfunction

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat, output int nr, output int nw,
                        output int nad, output logic [31:0] ww);
        int g;
        g = 0; rd = 0; er = 0; lat = 0; nr = 0; nw = 0; nad = 0; ww = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 10) begin @(negedge clk); g++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_read) nr++;
            if (bus.mem_write) begin nw++; ww = bus.mem_wdata; end
            if ((bus.mem_read || bus.mem_write) && bus.mem_addr != {a[31:2], 2'b00}) nad++;
            if (!(bus.mem_read || bus.mem_write) && bus.mem_addr != 0) nad++;
            if (!bus.mem_write && bus.mem_wdata != 0) nad++;
            if (bus.mem_read && bus.mem_write) nad++;
            if (!bus.resp_valid && (bus.resp_rdata != 0 || bus.resp_err)) nad++;
            if (bus.resp_valid) begin lat = i; rd = bus.resp_rdata; er = bus.resp_err; break; end
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t tv[15];
    logic [31:0] mrd, drd, mww, dww, a, d;
    logic mer, der, we;
    logic [2:0] f3;
    int mlat, dlat, mnr, dnr, mnw, dnw, nad, r;
    logic [7:0] rmask, ymask;
    logic [2:0] lf [5];

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
        for (int i = 0; i < 64; i++) for (int j = 0; j < 4; j++) refm[4 * i + j] = init_word(i) >> (8 * j);
        tv[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2};
        tv[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2};
        tv[2]  = '{1'b1, 3'b000, 32'h11,  32'h000000AA, 32'h0,        1'b0, 3};
        tv[3]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 1'b0, 2};
        tv[4]  = '{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0, 2};
        tv[5]  = '{1'b0, 3'b100, 32'h11,  32'h0,        32'h000000AA, 1'b0, 2};
        tv[6]  = '{1'b1, 3'b001, 32'h12,  32'h00008234, 32'h0,        1'b0, 3};
        tv[7]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h8234AAEF, 1'b0, 2};
        tv[8]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8234, 1'b0, 2};
        tv[9]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h00008234, 1'b0, 2};
        tv[10] = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1, 1};
        tv[11] = '{1'b0, 3'b010, 32'h13,  32'h0,        32'h0,        1'b1, 1};
        tv[12] = '{1'b1, 3'b001, 32'h01,  32'h00001234, 32'h0,        1'b1, 1};
        tv[13] = '{1'b1, 3'b100, 32'h20,  32'h12345678, 32'h0,        1'b1, 1};
        tv[14] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1, 1};
        lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 0; load = 0;

        for (int i = 0; i < 15; i++) begin
            model(tv[i].we, tv[i].f3, tv[i].a, tv[i].d, mrd, mer, mlat, mnr, mnw, mww);
            xact(tv[i].we, tv[i].f3, tv[i].a, tv[i].d, drd, der, dlat, dnr, dnw, nad, dww);
            chk($sformatf("tv%0d_rdata", i), drd, tv[i].rd);
            chk($sformatf("tv%0d_err", i), der, tv[i].er);
            chk($sformatf("tv%0d_lat", i), dlat, tv[i].lat);
            chk($sformatf("tv%0d_nread", i), dnr, mnr);
            chk($sformatf("tv%0d_nwrite", i), dnw, mnw);
            chk($sformatf("tv%0d_bus", i), nad, 0);
            if (mnw != 0) chk($sformatf("tv%0d_wword", i), dww, mww);
        end

        // Request held high across an SB: the queued LW is taken only after the SB response
        model(1'b1, 3'b000, 32'h22, 32'h0000005C, mrd, mer, mlat, mnr, mnw, mww);
        model(1'b0, 3'b010, 32'h20, 32'h0, mrd, mer, mlat, mnr, mnw, mww);
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h22; bus.req_wdata = 32'h5C;
        @(posedge clk);
        #1 bus.req_we = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h20;
        rmask = 0; ymask = 0; drd = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            rmask[i] = bus.resp_valid;
            ymask[i] = bus.req_ready;
            if (i == 6) drd = bus.resp_rdata;
            if (i == 5) bus.req_valid = 0;
        end
        chk("hold_resp_cycles", rmask, 8'h48);
        chk("hold_ready_cycles", ymask, 8'h90);
        chk("hold_lw_rdata", drd, mrd);

        // Back-to-back LW with request held: one issue every three cycles
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h20;
        @(posedge clk);
        rmask = 0; ymask = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            rmask[i] = bus.resp_valid;
            ymask[i] = bus.req_ready;
            if (bus.resp_valid) chk("b2b_rdata", bus.resp_rdata, mrd);
            if (i == 7) bus.req_valid = 0;
        end
        chk("b2b_resp_cycles", rmask, 8'h24);
        chk("b2b_ready_cycles", ymask, 8'h48);
        repeat (3) @(negedge clk);

        // Reset during the read phase of an SB aborts it without touching memory
        bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        chk("abort_in_rd", bus.mem_read, 1);
        rst = 1;
        #1;
        chk("abort_mem_rw", {bus.mem_read, bus.mem_write}, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        chk("abort_ready", bus.req_ready, 1);
        @(negedge clk);
        rst = 0;
        rmask = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rmask[i] = bus.resp_valid | bus.mem_write;
        end
        chk("abort_quiet", rmask, 0);
        model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer, mlat, mnr, mnw, mww);
        xact(1'b0, 3'b010, 32'h10, 32'h0, drd, der, dlat, dnr, dnw, nad, dww);
        chk("abort_word_kept", drd, mrd);
        chk("abort_word_value", drd, 32'h8234AAEF);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : lf[$urandom_range(0, 4)];
            a = (r == 0) ? $urandom : (r == 1) ? 32'd256 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 255));
            if (r >= 8) a = a & ~32'd3;
            d = $urandom;
            model(we, f3, a, d, mrd, mer, mlat, mnr, mnw, mww);
            xact(we, f3, a, d, drd, der, dlat, dnr, dnw, nad, dww);
            chk("rnd_rdata", drd, mrd);
            chk("rnd_err", der, mer);
            chk("rnd_lat", dlat, mlat);
            chk("rnd_nread", dnr, mnr);
            chk("rnd_nwrite", dnw, mnw);
            chk("rnd_bus", nad, 0);
            if (mnw != 0) chk("rnd_wword", dww, mww);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
